block_1_access_decoder: RTL and testbench
=========================================

Name: block_1_access_decoder

Overview:
- Front-end stage directly upstream of the block_1 register array.
- Accepts one host access at a time and decodes its 7-bit byte address against the block_1 register map into a one-hot register select.
- Drives the access to the register array and waits for an acknowledge, bounded by a timeout.
- Returns read data and a status response to the host with valid/ready backpressure.

Parameters:
- TIMEOUT_CYCLES, 64, number of cycles in ACCESS without i_reg_ack before a timeout response (legal range 2..255).
- ADDRESS_WIDTH, 7, byte address width; fixed by the block_1 map.
- DATA_WIDTH, 32, bus data width; strobe width is DATA_WIDTH/8.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  synchronous reset, active-high.
- i_req_valid  input  1  host request valid.
- o_req_ready  output  1  decoder can accept a request.
- i_req_addr  input  7  byte address.
- i_req_write  input  1  1 = write, 0 = read.
- i_req_wdata  input  32  write data.
- i_req_strb  input  4  byte strobes.
- o_reg_valid  output  1  access in progress to the register array.
- o_reg_sel  output  17  one-hot register select.
- o_reg_write  output  1  latched write flag.
- o_reg_wdata  output  32  latched write data.
- o_reg_strb  output  4  latched strobes.
- i_reg_ack  input  1  register array completed the access.
- i_reg_err  input  1  slave error; sampled only with i_reg_ack.
- i_reg_rdata  input  32  read data; sampled only with i_reg_ack.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  host accepts the response.
- o_rsp_rdata  output  32  read data; 0 for writes and errors.
- o_rsp_status  output  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT.

Behaviour:
- Clock and reset: one clock i_clk; i_rst is synchronous and active-high.
- Reset values: state IDLE; o_req_ready=1; o_reg_valid=0; o_reg_sel=0; o_reg_write=0; o_reg_wdata=0; o_reg_strb=0; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_status=00; timeout counter=0.
- Address map, index to byte address:
  - sel[0]=0x00, sel[1]=0x04.
  - sel[2]=0x10, a shared window for both register_file_1 registers.
  - sel[3..8]=0x20,0x24,0x28,0x2C,0x30,0x34.
  - sel[9]=0x38.
  - sel[10..15]=0x3C,0x40,0x44,0x48,0x4C,0x50.
  - sel[16]=0x54.
- Decode errors: any other address, or addr[1:0]!=0, is DECERR.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch addr, write, wdata and strb.
  - If the address hits: go to ACCESS next cycle with o_reg_valid=1 and o_reg_sel one-hot. Request-to-o_reg_valid latency is 1 cycle.
  - If the address misses: go to RESP with DECERR, rdata=0, and never assert o_reg_valid.
- ACCESS:
  - o_req_ready=0. Outputs are held stable. The counter increments every cycle.
  - On i_reg_ack: capture rdata (reads only) and status (SLVERR if i_reg_err, else OK); drop o_reg_valid and o_reg_sel; go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to RESP with TIMEOUT, rdata=0.
  - If ack and the timeout fire in the same cycle, ack wins.
  - Minimum access length: ack in the first ACCESS cycle, giving a 1-cycle access.
- RESP:
  - o_rsp_valid=1; data and status are held until i_rsp_ready.
  - On handshake: go to IDLE and clear the counter.
  - No new request is accepted in the handshake cycle, so there is one idle cycle between responses.
- Stray acks: i_reg_ack outside ACCESS, including a late ack after a timeout, is ignored.
- Zero strobes: a write with strb=0 is still forwarded; the register array decides what to do with it.
- Reset mid-operation: i_rst in any state returns to reset values next cycle. The in-flight access is dropped and no response is produced.
- Counter width: 8 bits, saturating; it never wraps.

Decomposition:
- Package block_1_access_pkg holds:
  - status enum (OK/SLVERR/DECERR/TIMEOUT);
  - REGISTER_COUNT=17;
  - a 17-entry byte-offset table whose values equal the block_1 register map constants.
- Decode loops over this table.
- One natural sub-module, block_1_address_lookup: combinational addr → {hit, one-hot sel}. The FSM, latches and counter stay in the top.

Test Plan:
- Read 0x04, ack after 3 cycles with rdata=0xA5 → o_reg_sel=17'h00002 for exactly 3 cycles; response rdata=0x000000A5, status=00.
- Write 0x54, wdata=0x1, strb=4'h1, ack next cycle → sel[16] set, o_reg_write=1; response status=00, rdata=0.
- Read 0x08, then 0x22 → no o_reg_valid for either; both respond DECERR (10) one cycle after acceptance.
- Read 0x3C with no ack → o_reg_valid held 64 cycles; TIMEOUT (11); a late ack in IDLE produces no response.
- Ack with i_reg_err=1 on 0x10 while i_rsp_ready=0 for 5 cycles → SLVERR held stable and o_req_ready=0 until handshake.
- Assert i_rst during ACCESS on 0x20 → next cycle all outputs at reset values; the next request to 0x00 completes normally.

Source files
------------

// File: rtl/block_1_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_1_access_pkg
// Description : Shared types and constants for the block_1 access decoder.
//               Holds the response status encoding, the register count and
//               the byte-offset table of the block_1 register map.
// Revision    : 1.0 - initial release
// ============================================================================
package block_1_access_pkg;

  localparam int REGISTER_COUNT = 17;
  localparam int ADDR_W         = 7;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_DECERR  = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_status_e;

  // Byte offset of each register select, index = one-hot bit position.
  // Entry 2 is the shared window covering both register_file_1 registers.
  localparam logic [ADDR_W-1:0] REG_OFFSET [REGISTER_COUNT] = '{
    7'h00, 7'h04, 7'h10, 7'h20, 7'h24, 7'h28, 7'h2C, 7'h30, 7'h34,
    7'h38, 7'h3C, 7'h40, 7'h44, 7'h48, 7'h4C, 7'h50, 7'h54
  };

endpackage
`default_nettype wire

// File: rtl/block_1_address_lookup.sv
`default_nettype none
// ============================================================================
// Module      : block_1_address_lookup
// Description : Combinational decode of a byte address against the block_1
//               register map into a hit flag and a one-hot register select.
// Ports       : addr_i - byte address
//               hit_o  - address matches a mapped, word-aligned register
//               sel_o  - one-hot register select (all zero on a miss)
// Revision    : 1.0 - initial release
// ============================================================================
module block_1_address_lookup
  import block_1_access_pkg::*;
(
  input  logic [ADDR_W-1:0]         addr_i,
  output logic                      hit_o,
  output logic [REGISTER_COUNT-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    // Every table entry is word aligned; the explicit check keeps a
    // misaligned address from ever matching if the table is edited.
    if (addr_i[1:0] == 2'b00) begin
      for (int i = 0; i < REGISTER_COUNT; i++) begin
        if (addr_i == REG_OFFSET[i]) begin
          sel_o[i] = 1'b1;
        end
      end
    end
  end

  assign hit_o = |sel_o;

endmodule
`default_nettype wire

// File: rtl/block_1_access_decoder.sv
`default_nettype none
// ============================================================================
// Module      : block_1_access_decoder
// Description : Host-side front end of the block_1 register array. Accepts
//               one access at a time, decodes it to a one-hot register
//               select, waits for the array acknowledge (bounded by a
//               timeout) and returns data plus status with valid/ready.
// Ports       : i_clk, i_rst           - clock, synchronous active-high reset
//               i_req_*, o_req_ready   - host request channel
//               o_reg_*, i_reg_*       - register array access channel
//               o_rsp_*, i_rsp_ready   - host response channel
// Revision    : 1.0 - initial release
// ============================================================================
module block_1_access_decoder
  import block_1_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  // host request
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_req_addr,
  input  logic                      i_req_write,
  input  logic [DATA_WIDTH-1:0]     i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_req_strb,
  // register array
  output logic                      o_reg_valid,
  output logic [REGISTER_COUNT-1:0] o_reg_sel,
  output logic                      o_reg_write,
  output logic [DATA_WIDTH-1:0]     o_reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_reg_strb,
  input  logic                      i_reg_ack,
  input  logic                      i_reg_err,
  input  logic [DATA_WIDTH-1:0]     i_reg_rdata,
  // host response
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                o_rsp_status
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Last counter value of an access before it is declared timed out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                    state_q;
  logic                      req_ready_q;
  logic                      reg_valid_q;
  logic [REGISTER_COUNT-1:0] reg_sel_q;
  logic                      reg_write_q;
  logic [DATA_WIDTH-1:0]     reg_wdata_q;
  logic [DATA_WIDTH/8-1:0]   reg_strb_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  rsp_status_e               rsp_status_q;
  logic [7:0]                cnt_q;
  logic [7:0]                cnt_d;

  logic                      lookup_hit;
  logic [REGISTER_COUNT-1:0] lookup_sel;

  block_1_address_lookup u_lookup (
    .addr_i (i_req_addr),
    .hit_o  (lookup_hit),
    .sel_o  (lookup_sel)
  );

  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      reg_valid_q  <= 1'b0;
      reg_sel_q    <= '0;
      reg_write_q  <= 1'b0;
      reg_wdata_q  <= '0;
      reg_strb_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RSP_OK;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            req_ready_q <= 1'b0;
            reg_write_q <= i_req_write;
            reg_wdata_q <= i_req_wdata;
            reg_strb_q  <= i_req_strb;
            if (lookup_hit) begin
              state_q     <= ST_ACCESS;
              reg_valid_q <= 1'b1;
              reg_sel_q   <= lookup_sel;
            end else begin
              // Unmapped address: answer directly, the array never sees it.
              state_q      <= ST_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_rdata_q  <= '0;
              rsp_status_q <= RSP_DECERR;
            end
          end
        end

        ST_ACCESS: begin
          cnt_q <= cnt_d;
          // Ack is tested first so it wins over a coincident timeout.
          if (i_reg_ack) begin
            state_q      <= ST_RESP;
            reg_valid_q  <= 1'b0;
            reg_sel_q    <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= i_reg_err ? RSP_SLVERR : RSP_OK;
            rsp_rdata_q  <= (!reg_write_q && !i_reg_err) ? i_reg_rdata : '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q      <= ST_RESP;
            reg_valid_q  <= 1'b0;
            reg_sel_q    <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= RSP_TIMEOUT;
            rsp_rdata_q  <= '0;
          end
        end

        ST_RESP: begin
          // Ready is only restored the cycle after the handshake, which
          // leaves one idle cycle between consecutive responses.
          if (i_rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cnt_q       <= '0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          reg_valid_q <= 1'b0;
          reg_sel_q   <= '0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_reg_valid  = reg_valid_q;
  assign o_reg_sel    = reg_sel_q;
  assign o_reg_write  = reg_write_q;
  assign o_reg_wdata  = reg_wdata_q;
  assign o_reg_strb   = reg_strb_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_rdata  = rsp_rdata_q;
  assign o_rsp_status = rsp_status_q;

endmodule
`default_nettype wire

// File: tb/tb_block_1_access_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_1_access_decoder
// Description : Self-checking bench for block_1_access_decoder. A driver
//               issues requests and plays the register array; expected
//               responses go into a queue that a separate monitor pops on
//               each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_1_access_decoder;

  localparam int TIMEOUT = 64;
  localparam logic [6:0] MAP [17] = '{
    7'h00, 7'h04, 7'h10, 7'h20, 7'h24, 7'h28, 7'h2C, 7'h30, 7'h34,
    7'h38, 7'h3C, 7'h40, 7'h44, 7'h48, 7'h4C, 7'h50, 7'h54
  };

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } rsp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [6:0]  i_req_addr = '0;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_strb = '0;
  logic        o_reg_valid;
  logic [16:0] o_reg_sel;
  logic        o_reg_write;
  logic [31:0] o_reg_wdata;
  logic [3:0]  o_reg_strb;
  logic        i_reg_ack = 1'b0;
  logic        i_reg_err = 1'b0;
  logic [31:0] i_reg_rdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_status;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   hold_low = 0;
  rsp_t exp_q[$];

  block_1_access_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_write  (i_req_write),
    .i_req_wdata  (i_req_wdata),
    .i_req_strb   (i_req_strb),
    .o_reg_valid  (o_reg_valid),
    .o_reg_sel    (o_reg_sel),
    .o_reg_write  (o_reg_write),
    .o_reg_wdata  (o_reg_wdata),
    .o_reg_strb   (o_reg_strb),
    .i_reg_ack    (i_reg_ack),
    .i_reg_err    (i_reg_err),
    .i_reg_rdata  (i_reg_rdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_status (o_rsp_status)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within bound", nm);
  endtask

  function automatic int map_index(input logic [6:0] a);
    for (int i = 0; i < 17; i++) if (MAP[i] == a) return i;
    return -1;
  endfunction

  // Reference model: outcome of one access from the map and ack behaviour.
  function automatic rsp_t model(input logic [6:0] a, input logic wr, input int ack_dly,
                                 input logic err, input logic [31:0] rd);
    rsp_t r;
    r.rdata = 32'h0;
    if (map_index(a) < 0)  r.status = 2'b10;
    else if (ack_dly == 0) r.status = 2'b11;
    else if (err)          r.status = 2'b01;
    else begin
      r.status = 2'b00;
      r.rdata  = wr ? 32'h0 : rd;
    end
    return r;
  endfunction

  task automatic check_reset_values();
    chk("rst_req_ready",  o_req_ready,  1);
    chk("rst_reg_valid",  o_reg_valid,  0);
    chk("rst_reg_sel",    o_reg_sel,    0);
    chk("rst_reg_write",  o_reg_write,  0);
    chk("rst_reg_wdata",  o_reg_wdata,  0);
    chk("rst_reg_strb",   o_reg_strb,   0);
    chk("rst_rsp_valid",  o_rsp_valid,  0);
    chk("rst_rsp_rdata",  o_rsp_rdata,  0);
    chk("rst_rsp_status", o_rsp_status, 0);
  endtask

  // Waits for o_req_ready, then presents a request at a negedge.
  task automatic issue(input logic [6:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, output bit ok);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 500) begin
      i_reg_ack = $urandom_range(0, 1);
      @(negedge i_clk);
      n++;
    end
    i_reg_ack = 1'b0;
    i_reg_err = 1'b0;
    ok = o_req_ready;
    if (!ok) begin
      fail_now("req_ready_wait");
      return;
    end
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_write = wr;
    i_req_wdata = wd;
    i_req_strb  = st;
  endtask

  // One complete access. ack_dly = ACCESS cycle of the ack, 0 = never ack.
  task automatic do_txn(input logic [6:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input int ack_dly, input logic err,
                        input logic [31:0] rd, input int gap);
    int   idx;
    int   cnt;
    bit   ok;
    logic [16:0] exp_sel;
    idx = map_index(a);
    // Idle cycles with stray acks, which must not produce anything.
    for (int g = 0; g < gap; g++) begin
      @(negedge i_clk);
      i_reg_ack   = $urandom_range(0, 1);
      i_reg_err   = $urandom_range(0, 1);
      i_reg_rdata = $urandom;
    end
    issue(a, wr, wd, st, ok);
    if (!ok) return;
    exp_q.push_back(model(a, wr, ack_dly, err, rd));
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    if (idx < 0) begin
      chk("miss_reg_valid", o_reg_valid, 0);
      chk("miss_rsp_valid", o_rsp_valid, 1);
    end else begin
      exp_sel = 17'h1 << idx;
      cnt = 0;
      while (o_reg_valid && cnt < 300) begin
        cnt++;
        chk("reg_sel",   o_reg_sel,   exp_sel);
        chk("reg_write", o_reg_write, wr);
        chk("reg_wdata", o_reg_wdata, wd);
        chk("reg_strb",  o_reg_strb,  st);
        if (cnt == ack_dly) begin
          i_reg_ack   = 1'b1;
          i_reg_err   = err;
          i_reg_rdata = rd;
        end
        @(posedge i_clk);
        #1;
        i_reg_ack = 1'b0;
        i_reg_err = 1'b0;
      end
      chk("access_cycles", cnt, (ack_dly == 0) ? TIMEOUT : ack_dly);
      chk("sel_cleared", o_reg_sel, 0);
      chk("rsp_valid_after_access", o_rsp_valid, 1);
    end
  endtask

  // Monitor: randomises ready, checks hold stability, pops on handshake.
  initial begin : mon
    bit   stall_prev;
    rsp_t prev;
    rsp_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        i_rsp_ready = 1'b0;
        stall_prev  = 1'b0;
        continue;
      end
      if (hold_low > 0 && o_rsp_valid) begin
        i_rsp_ready = 1'b0;
        hold_low--;
      end else begin
        i_rsp_ready = ($urandom_range(0, 2) != 0);
      end
      #1;
      if (stall_prev) begin
        chk("rsp_hold_valid",  o_rsp_valid,  1);
        chk("rsp_hold_rdata",  o_rsp_rdata,  prev.rdata);
        chk("rsp_hold_status", o_rsp_status, prev.status);
      end
      if (o_rsp_valid) begin
        chk("req_ready_in_resp", o_req_ready, 0);
        if (i_rsp_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got status %0h rdata %0h, expected no response",
                     o_rsp_status, o_rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_status", o_rsp_status, e.status);
            chk("rsp_rdata",  o_rsp_rdata,  e.rdata);
          end
        end else begin
          stall_prev   = 1'b1;
          prev.rdata   = o_rsp_rdata;
          prev.status  = o_rsp_status;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin : drv
    bit          ok;
    logic [6:0]  a;
    int          ad;
    int          n;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values();
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed cases
    do_txn(7'h04, 1'b0, 32'h0,        4'h0, 3, 1'b0, 32'h0000_00A5, 0);
    do_txn(7'h54, 1'b1, 32'h1,        4'h1, 1, 1'b0, 32'hFFFF_FFFF, 0);
    do_txn(7'h08, 1'b0, 32'h0,        4'h0, 1, 1'b0, 32'h0,         0);
    do_txn(7'h22, 1'b0, 32'h0,        4'h0, 1, 1'b0, 32'h0,         0);
    do_txn(7'h3C, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'h0,         0);
    do_txn(7'h00, 1'b1, 32'h1234_5678, 4'h0, 2, 1'b0, 32'h0,        3);
    hold_low = 5;
    do_txn(7'h10, 1'b0, 32'h0,        4'h0, 2, 1'b1, 32'hDEAD_0001, 0);

    // Reset in the middle of an ACCESS to 0x20
    issue(7'h20, 1'b1, 32'hDEAD_BEEF, 4'hF, ok);
    if (ok) begin
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      chk("rstmid_reg_valid", o_reg_valid, 1);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check_reset_values();
      @(negedge i_clk);
      i_rst = 1'b0;
    end
    do_txn(7'h00, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'hCAFE_F00D, 0);

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      a  = ($urandom_range(0, 9) < 6) ? MAP[$urandom_range(0, 16)] : 7'($urandom);
      ad = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      do_txn(a, 1'($urandom), $urandom, 4'($urandom), ad,
             ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 2));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_responses");
    repeat (5) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
